// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter: first bit one cycle after load, WIDTH+2 cycles/word minimum.
// Load accepted only in IDLE; serial beats hold (register and ser_out) while ser_ready is low.
module piso_shift_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (load_valid) state_nxt = ST_SHIFT;
      ST_SHIFT: if (ser_ready && (cnt == LAST)) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Counter saturates at LAST; it is re-zeroed on every accepted load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg <= '0;
      cnt   <= '0;
    end else if ((state == ST_IDLE) && load_valid) begin
      shreg <= load_data;
      cnt   <= '0;
    end else if ((state == ST_SHIFT) && ser_ready) begin
      if (MSB_FIRST) begin
        shreg <= {shreg[WIDTH-2:0], 1'b0};
      end else begin
        shreg <= {1'b0, shreg[WIDTH-1:1]};
      end
      if (cnt != LAST) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // All outputs decode registered state only; the word is fully drained to
  // zeros by the time DONE is reached, so ser_out idles low.
  assign load_ready = (state == ST_IDLE);
  assign ser_valid  = (state == ST_SHIFT);
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);
  assign ser_out    = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

endmodule
